// File: rtl/merlin_timer_pkg.sv
// Shared constants for the merlin data-port machine timer.
//   OFS_*      register offsets within the timer window (addr[4:0])
//   CTRL_*     bit positions inside the CTRL register
//   SZ_WORD    treqsize encoding of the only legal access size
//   ofs_mapped returns 1 when an aligned offset hits a real register
package merlin_timer_pkg;

   localparam logic [4:0] OFS_MTIME_LO = 5'h00;
   localparam logic [4:0] OFS_MTIME_HI = 5'h04;
   localparam logic [4:0] OFS_CMP_LO   = 5'h08;
   localparam logic [4:0] OFS_CMP_HI   = 5'h0C;
   localparam logic [4:0] OFS_CTRL     = 5'h10;
   localparam logic [4:0] OFS_PRESCALE = 5'h14;

   localparam int unsigned CTRL_EN = 0;
   localparam int unsigned CTRL_IE = 1;

   localparam logic [1:0] SZ_WORD = 2'b10;

   // 0x18 and 0x1C are the only holes in the 32-byte window.
   function automatic logic ofs_mapped(input logic [4:0] ofs);
      return ofs <= OFS_PRESCALE;
   endfunction

endpackage

// File: rtl/merlin_timer_counter.sv
// Prescaler plus 64-bit mtime counter.
//   clk_i, reset_i   clock and synchronous active-high reset
//   clk_en_i         global clock enable; all state holds when 0
//   en_i             CTRL.EN; freezes both the prescale count and mtime when 0
//   prescale_i       tick period minus one
//   wr_lo_i/wr_hi_i  software write strobes for the two mtime halves (at most one per cycle)
//   wdata_i          write data for the selected half
//   mtime_o          current 64-bit mtime
module merlin_timer_counter #(
   parameter int unsigned C_PRESCALE_W = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clk_en_i,
   input  logic                    en_i,
   input  logic [C_PRESCALE_W-1:0] prescale_i,
   input  logic                    wr_lo_i,
   input  logic                    wr_hi_i,
   input  logic [31:0]             wdata_i,
   output logic [63:0]             mtime_o
);

   logic [C_PRESCALE_W-1:0] r_cnt;
   logic [31:0]             r_lo;
   logic [31:0]             r_hi;

   logic                    w_tick;
   logic                    w_carry;
   logic [31:0]             w_lo_inc;
   logic [31:0]             w_lo_d;
   logic [31:0]             w_hi_d;
   logic [C_PRESCALE_W-1:0] w_cnt_d;

   assign w_tick = en_i & (r_cnt == prescale_i);

   always_comb begin
      w_cnt_d = r_cnt;
      if (en_i) begin
         w_cnt_d = w_tick ? '0 : r_cnt + C_PRESCALE_W'(1);
      end
   end

   assign {w_carry, w_lo_inc} = {1'b0, r_lo} + 33'(w_tick);

   // A software write owns its half; a write to LO also swallows the carry into HI.
   always_comb begin
      w_lo_d = wr_lo_i ? wdata_i : w_lo_inc;
      if (wr_hi_i) begin
         w_hi_d = wdata_i;
      end else if (wr_lo_i) begin
         w_hi_d = r_hi;
      end else begin
         w_hi_d = r_hi + 32'(w_carry);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_cnt <= '0;
         r_lo  <= '0;
         r_hi  <= '0;
      end else if (clk_en_i) begin
         r_cnt <= w_cnt_d;
         r_lo  <= w_lo_d;
         r_hi  <= w_hi_d;
      end
   end

   assign mtime_o = {r_hi, r_lo};

endmodule

// File: rtl/merlin_dport_timer.sv
// Memory-mapped machine timer on the merlin data port.
//   clk_i, reset_i, clk_en_i       clock, synchronous active-high reset, clock enable
//   treq*                          request channel (valid/ready, size, write, addr, data)
//   trsp*                          response channel (valid/ready, rerr, werr, data)
//   irq_timer_o                    registered level interrupt: IE & (mtime >= mtimecmp)
// One-entry response register: a request is accepted whenever the slot is empty or being drained.
module merlin_dport_timer
   import merlin_timer_pkg::*;
#(
   parameter int unsigned C_PRESCALE_W = 16,
   parameter logic [63:0] C_RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   output logic        treqready_o,
   input  logic        treqvalid_i,
   input  logic [1:0]  treqsize_i,
   input  logic        treqwrite_i,
   input  logic [31:0] treqaddr_i,
   input  logic [31:0] treqdata_i,
   input  logic        trspready_i,
   output logic        trspvalid_o,
   output logic        trsprerr_o,
   output logic        trspwerr_o,
   output logic [31:0] trspdata_o,
   output logic        irq_timer_o
);

   logic                    r_rspvalid;
   logic                    r_rerr;
   logic                    r_werr;
   logic [31:0]             r_rdata;
   logic [63:0]             r_cmp;
   logic [1:0]              r_ctrl;
   logic [C_PRESCALE_W-1:0] r_prescale;
   logic [31:0]             r_hi_shadow;
   logic                    r_irq;

   logic [4:0]              w_ofs;
   logic                    w_err;
   logic                    w_accept;
   logic                    w_wr_ok;
   logic                    w_rd_ok;
   logic                    w_wr_lo;
   logic                    w_wr_hi;
   logic [31:0]             w_rdata;
   logic [63:0]             w_mtime;
   logic                    w_unused_addr;

   assign w_ofs         = treqaddr_i[4:0];
   assign w_unused_addr = ^treqaddr_i[31:5];

   assign treqready_o = ~r_rspvalid | trspready_i;
   assign w_accept    = clk_en_i & treqvalid_i & treqready_o;

   assign w_err = (treqsize_i != SZ_WORD) | (treqaddr_i[1:0] != 2'b00) | ~ofs_mapped(w_ofs);

   assign w_wr_ok = w_accept & treqwrite_i & ~w_err;
   assign w_rd_ok = w_accept & ~treqwrite_i & ~w_err;
   assign w_wr_lo = w_wr_ok & (w_ofs == OFS_MTIME_LO);
   assign w_wr_hi = w_wr_ok & (w_ofs == OFS_MTIME_HI);

   merlin_timer_counter #(
      .C_PRESCALE_W (C_PRESCALE_W)
   ) u_counter (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clk_en_i   (clk_en_i),
      .en_i       (r_ctrl[CTRL_EN]),
      .prescale_i (r_prescale),
      .wr_lo_i    (w_wr_lo),
      .wr_hi_i    (w_wr_hi),
      .wdata_i    (treqdata_i),
      .mtime_o    (w_mtime)
   );

   // MTIME_HI returns the value captured by the last MTIME_LO read so LO/HI pairs are coherent.
   always_comb begin
      w_rdata = '0;
      case (w_ofs)
         OFS_MTIME_LO: w_rdata = w_mtime[31:0];
         OFS_MTIME_HI: w_rdata = r_hi_shadow;
         OFS_CMP_LO:   w_rdata = r_cmp[31:0];
         OFS_CMP_HI:   w_rdata = r_cmp[63:32];
         OFS_CTRL:     w_rdata = {30'd0, r_ctrl};
         OFS_PRESCALE: w_rdata = 32'(r_prescale);
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rspvalid <= 1'b0;
         r_rerr     <= 1'b0;
         r_werr     <= 1'b0;
         r_rdata    <= '0;
      end else if (clk_en_i) begin
         if (w_accept) begin
            r_rspvalid <= 1'b1;
            r_rerr     <= w_err & ~treqwrite_i;
            r_werr     <= w_err & treqwrite_i;
            r_rdata    <= w_rd_ok ? w_rdata : '0;
         end else if (trspready_i) begin
            r_rspvalid <= 1'b0;
            r_rerr     <= 1'b0;
            r_werr     <= 1'b0;
            r_rdata    <= '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_cmp       <= C_RESET_CMP;
         r_ctrl      <= '0;
         r_prescale  <= '0;
         r_hi_shadow <= '0;
      end else if (clk_en_i) begin
         if (w_wr_ok && w_ofs == OFS_CMP_LO) begin
            r_cmp[31:0] <= treqdata_i;
         end
         if (w_wr_ok && w_ofs == OFS_CMP_HI) begin
            r_cmp[63:32] <= treqdata_i;
         end
         if (w_wr_ok && w_ofs == OFS_CTRL) begin
            r_ctrl <= treqdata_i[1:0];
         end
         if (w_wr_ok && w_ofs == OFS_PRESCALE) begin
            r_prescale <= treqdata_i[C_PRESCALE_W-1:0];
         end
         if (w_rd_ok && w_ofs == OFS_MTIME_LO) begin
            r_hi_shadow <= w_mtime[63:32];
         end
      end
   end

   // Compare uses registered mtime/mtimecmp, so irq lags any change by one cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_irq <= 1'b0;
      end else if (clk_en_i) begin
         r_irq <= r_ctrl[CTRL_IE] & (w_mtime >= r_cmp);
      end
   end

   assign trspvalid_o = r_rspvalid;
   assign trsprerr_o  = r_rerr;
   assign trspwerr_o  = r_werr;
   assign trspdata_o  = r_rdata;
   assign irq_timer_o = r_irq;

endmodule
